balanca_peso: RTL and testbench



---
 rtl/balanca_pkg.sv | 16 +
 rtl/estabilidade_det.sv | 47 ++++
 rtl/balanca_peso.sv | 133 +++++++++++++
 tb/tb_balanca_peso.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/balanca_pkg.sv
// Shared constants and types for the scale datapath; preco imports the
// same widths so weight_kg lines up on both sides.
package balanca_pkg;

    localparam int DEF_W          = 16;
    localparam int DEF_AVG_LOG2   = 2;
    localparam int DEF_MAX_WEIGHT = 30000;
    localparam int DEF_STABLE_TOL = 2;
    localparam int DEF_STABLE_CNT = 3;

    typedef enum logic {
        TARE_IDLE = 1'b0,
        TARE_PEND = 1'b1
    } tare_state_t;

endpackage

// File: rtl/estabilidade_det.sv
// Stability detector: counts consecutive published weights that stay within
// TOL of the previous one, saturating at CNT.
module estabilidade_det #(
    parameter int W   = 16,
    parameter int TOL = 2,
    parameter int CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         upd,
    input  logic [W-1:0] value,
    output logic         stable
);

    localparam int             CW      = $clog2(CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CNT);
    localparam logic [W-1:0]   TOL_W   = W'(TOL);

    logic [W-1:0]  r_prev;
    logic          r_has_prev;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_diff;
    logic          w_steady;

    assign w_diff   = (value >= r_prev) ? value - r_prev : r_prev - value;
    // Without a previous value there is nothing to compare against.
    assign w_steady = r_has_prev && (w_diff <= TOL_W);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_prev     <= '0;
            r_has_prev <= 1'b0;
            r_cnt      <= '0;
        end else if (upd) begin
            r_prev     <= value;
            r_has_prev <= 1'b1;
            if (!w_steady)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stable = (r_cnt == CNT_MAX);

endmodule

// File: rtl/balanca_peso.sv
// Weight acquisition: block average of raw samples, tare subtraction with
// underflow clamp, overload saturation, and a stability flag.
module balanca_peso
    import balanca_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int AVG_LOG2   = DEF_AVG_LOG2,
    parameter int STABLE_TOL = DEF_STABLE_TOL,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int MAX_WEIGHT = DEF_MAX_WEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        raw_valid,
    input  logic [W-1:0] raw_sample,
    input  logic        tare_req,
    output logic [W-1:0] weight_kg,
    output logic        weight_valid,
    output logic        stable,
    output logic        overload,
    output logic        tare_active,
    output tare_state_t dbg_tare_state
);

    localparam int                  AW    = W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] LAST  = '1;
    localparam logic [W-1:0]        MAX_W = W'(MAX_WEIGHT);

    // Handshake: raw_valid qualifies raw_sample each cycle (no backpressure);
    // weight_valid is a single-cycle strobe, weight_kg holds until the next one.
    logic [AW-1:0]       r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [W-1:0]        r_avg;
    logic                r_avg_new;
    logic [AW-1:0]       w_sum;

    assign w_sum = r_acc + AW'(raw_sample);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_avg     <= '0;
            r_avg_new <= 1'b0;
        end else begin
            r_avg_new <= 1'b0;
            if (raw_valid) begin
                if (r_cnt == LAST) begin
                    r_avg     <= w_sum[AW-1:AVG_LOG2];
                    r_avg_new <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    tare_state_t  r_state;
    logic [W-1:0] r_tare;
    logic [W-1:0] r_weight;
    logic         r_valid;
    logic         r_overload;
    logic         r_tare_active;
    logic         w_over;
    logic         w_capture;
    logic [W-1:0] w_net;
    logic         w_stab_clr;
    logic         w_stab_upd;

    assign w_over     = (r_avg > MAX_W);
    assign w_net      = (r_avg >= r_tare) ? r_avg - r_tare : '0;
    assign w_capture  = r_avg_new && !w_over && (r_state == TARE_PEND);
    assign w_stab_clr = r_avg_new && (w_over || (r_state == TARE_PEND));
    assign w_stab_upd = r_avg_new && !w_over && (r_state == TARE_IDLE);

    // Publish stage and tare FSM share one register block; the state seen by
    // a publish is the one before any tare_req arriving on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= TARE_IDLE;
            r_tare        <= '0;
            r_weight      <= '0;
            r_valid       <= 1'b0;
            r_overload    <= 1'b0;
            r_tare_active <= 1'b0;
        end else begin
            r_valid <= r_avg_new;
            case (r_state)
                TARE_IDLE: if (tare_req)  r_state <= TARE_PEND;
                TARE_PEND: if (w_capture) r_state <= TARE_IDLE;
                default:                  r_state <= TARE_IDLE;
            endcase
            if (r_avg_new) begin
                if (w_over) begin
                    r_weight   <= MAX_W;
                    r_overload <= 1'b1;
                end else begin
                    r_overload <= 1'b0;
                    if (r_state == TARE_PEND) begin
                        r_tare        <= r_avg;
                        r_tare_active <= (r_avg != '0);
                        r_weight      <= '0;
                    end else begin
                        r_weight <= w_net;
                    end
                end
            end
        end
    end

    estabilidade_det #(
        .W   (W),
        .TOL (STABLE_TOL),
        .CNT (STABLE_CNT)
    ) u_estab (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_stab_clr),
        .upd    (w_stab_upd),
        .value  (w_net),
        .stable (stable)
    );

    assign weight_kg      = r_weight;
    assign weight_valid   = r_valid;
    assign overload       = r_overload;
    assign tare_active    = r_tare_active;
    assign dbg_tare_state = r_state;

endmodule

// File: tb/tb_balanca_peso.sv
// Bench for balanca_peso: directed scenarios then random blocks, each cycle
// checked against a block-level behavioural model of the scale.
module tb_balanca_peso;
    import balanca_pkg::*;

    localparam int MAXW = 30000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        raw_valid = 1'b0;
    logic [15:0] raw_sample = '0;
    logic        tare_req = 1'b0;
    logic [15:0] weight_kg;
    logic        weight_valid;
    logic        stable;
    logic        overload;
    logic        tare_active;
    tare_state_t dbg_tare_state;

    balanca_peso dut (
        .clk            (clk),
        .rst            (rst),
        .raw_valid      (raw_valid),
        .raw_sample     (raw_sample),
        .tare_req       (tare_req),
        .weight_kg      (weight_kg),
        .weight_valid   (weight_valid),
        .stable         (stable),
        .overload       (overload),
        .tare_active    (tare_active),
        .dbg_tare_state (dbg_tare_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int blk[$];
    bit m_pub_pending = 0;
    int m_pub_avg = 0;
    int m_tare = 0;
    bit m_tpend = 0;
    int m_weight = 0;
    bit m_valid = 0;
    bit m_ovl = 0;
    int m_scnt = 0;
    bit m_has_prev = 0;
    int m_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_publish(input int avg, input bit old_pend);
        int net;
        int d;
        if (avg > MAXW) begin
            m_weight = MAXW; m_ovl = 1; m_scnt = 0; m_has_prev = 0;
        end else if (old_pend) begin
            m_ovl = 0; m_tare = avg; m_weight = 0;
            m_scnt = 0; m_has_prev = 0; m_tpend = 0;
        end else begin
            m_ovl = 0;
            net = (avg >= m_tare) ? avg - m_tare : 0;
            if (m_has_prev) begin
                d = (net > m_prev) ? net - m_prev : m_prev - net;
                m_scnt = (d <= 2) ? ((m_scnt < 3) ? m_scnt + 1 : 3) : 0;
            end else begin
                m_scnt = 0;
            end
            m_prev = net; m_has_prev = 1; m_weight = net;
        end
    endtask

    task automatic model_edge(input bit v, input int s, input bit t, input bit r);
        bit old_pend;
        int sum;
        if (r) begin
            blk.delete(); m_pub_pending = 0; m_tare = 0; m_tpend = 0;
            m_weight = 0; m_valid = 0; m_ovl = 0; m_scnt = 0; m_has_prev = 0; m_prev = 0;
            return;
        end
        m_valid = 0;
        old_pend = m_tpend;
        if (m_pub_pending) begin
            model_publish(m_pub_avg, old_pend);
            m_valid = 1;
            m_pub_pending = 0;
        end
        if (!old_pend && t) m_tpend = 1;
        if (v) begin
            blk.push_back(s);
            if (blk.size() == 4) begin
                sum = 0;
                foreach (blk[i]) sum += blk[i];
                m_pub_avg = sum >> 2;
                m_pub_pending = 1;
                blk.delete();
            end
        end
    endtask

    task automatic step(input bit v, input int s, input bit t, input bit r);
        raw_valid = v; raw_sample = 16'(s); tare_req = t; rst = r;
        @(posedge clk);
        model_edge(v, s, t, r);
        #1;
        chk("weight_valid", 32'(weight_valid), 32'(m_valid));
        chk("weight_kg", 32'(weight_kg), 32'(m_weight));
        chk("overload", 32'(overload), 32'(m_ovl));
        chk("stable", 32'(stable), 32'(m_scnt == 3));
        chk("tare_active", 32'(tare_active), 32'(m_tare != 0));
        chk("tare_state", 32'(dbg_tare_state), 32'(m_tpend ? TARE_PEND : TARE_IDLE));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic block(input int a, input int b, input int c, input int d,
                         input int gap_max, input int tr_pct);
        int smp[4];
        smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
        for (int i = 0; i < 4; i++) begin
            step(1, smp[i], ($urandom_range(0, 99) < tr_pct), 0);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    initial begin
        int base;
        int prev_base;
        int s[4];
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        block(100, 102, 98, 100, 0, 0);
        idle(3);
        block(1, 1, 1, 2, 0, 0);
        block(8, 8, 8, 8, 0, 0);
        idle(3);

        step(0, 0, 1, 0);
        block(100, 100, 100, 100, 0, 0);
        idle(2);
        block(600, 600, 600, 600, 0, 0);
        idle(2);
        block(80, 80, 80, 80, 0, 0);
        idle(2);

        step(0, 0, 1, 0);
        block(30001, 30001, 30001, 30001, 0, 0);
        idle(2);
        block(200, 200, 200, 200, 0, 0);
        idle(2);

        block(700, 700, 700, 700, 0, 0);
        block(701, 701, 701, 701, 0, 0);
        block(699, 699, 699, 699, 0, 0);
        block(700, 700, 700, 700, 0, 0);
        idle(2);
        block(710, 710, 710, 710, 0, 0);
        idle(2);

        step(1, 40, 0, 0);
        step(1, 40, 0, 0);
        step(0, 0, 0, 1);
        block(40, 40, 40, 40, 0, 0);
        idle(3);

        prev_base = 500;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: base = $urandom_range(0, 65532);
                1: base = $urandom_range(29990, 30010);
                2: base = prev_base + $urandom_range(0, 4) - 2;
                default: base = $urandom_range(0, 300);
            endcase
            if (base < 0) base = 0;
            if (base > 65532) base = 65532;
            for (int i = 0; i < 4; i++) s[i] = base + $urandom_range(0, 3);
            block(s[0], s[1], s[2], s[3], $urandom_range(0, 2), 8);
            prev_base = base;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
